ysyx_22050612_idu_stage: RTL and testbench
==========================================

Name: ysyx_22050612_idu_stage

Overview:
- Pipelined, parametrised instruction-decode stage between the fetch unit and the execute unit of the ysyx_22050612 core.
- Accepts one 32-bit RISC-V instruction per cycle over a valid/ready handshake.
- Decodes opcode class, register indices and a single format-selected immediate sign-extended to XLEN bits.
- Presents the result from a registered output with a one-entry skid buffer, so full throughput survives execute-side backpressure.

Parameters:
- XLEN, 64, datapath width; legal values 32 or 64. Immediates are sign-extended to XLEN. With XLEN=32, W-suffix ops, LD/SD and 6-bit shamt with bit5=1 are illegal.
- PC_W, 64, width of the PC carried alongside the instruction.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held/in-flight instructions (branch redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  raw instruction
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  decoded packet valid
- out_ready  in  1  execute accepts
- out_pc  out  PC_W  PC passed through
- out_op  out  OP_W  decoded operation enum (package idu_pkg)
- out_fmt  out  3  format enum R/I/S/B/U/J
- out_rd, out_rs1, out_rs2  out  5 each  register indices; forced to 0 when unused by the format
- out_imm  out  XLEN  sign-extended immediate; 0 for R-type
- out_shamt  out  6  shift amount (bit5 forced 0 for *W shifts)
- out_word  out  1  32-bit W-variant op
- out_illegal  out  1  unrecognised encoding
- out_ebreak  out  1  inst == 0x00100073

Behaviour:
- Reset: out_valid=0, skid empty, in_ready=1. All data outputs are 0 while rst is asserted and until the first load.
- Transfer happens when valid&&ready on the same edge. Decode is combinational on in_inst; results are registered, so latency is 1 cycle from accept to out_valid.
- Storage is a main register M plus a skid register S. in_ready = !S.valid, which is registered and does not depend combinationally on out_ready.
- Accept with M empty, or M draining this cycle: decoded packet goes to M.
- Accept with M full and not draining: packet goes to S.
- M drains while S is full: S moves to M and S empties.
- Simultaneous accept and drain: M is replaced, with no bubble.
- flush (priority over everything except rst): next cycle M.valid=0 and S.valid=0. An input presented in the flush cycle is dropped, although in_ready may read 1.
- Illegal encodings: passed through with out_op=OP_ILLEGAL and out_illegal=1. Never stalls.
- ebreak: out_op=OP_EBREAK and out_ebreak=1. Execute raises the trap; this stage does not.
- Base decode covers RV64I: LUI, AUIPC, JAL, JALR, all branches, all loads/stores, OP-IMM, OP, OP-IMM-32, OP-32, EBREAK, ECALL.
- Data outputs remain stable while out_valid && !out_ready.

Optional Feature:
- Macro: YSYX_22050612_IDU_MEXT_EN.
- Defined: decodes the RV64M set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW) to their OP_* enums, setting out_word for the W forms.
- Undefined: all funct7=0000001 OP/OP-32 encodings decode as OP_ILLEGAL with out_illegal=1.

Decomposition:
- Package idu_pkg holds:
  - op_e enum with OP_W localparam, including OP_ILLEGAL and OP_EBREAK;
  - fmt_e enum;
  - opcode constants (OPC_LUI=7'b0110111, etc.);
  - the decoded-packet struct.
- Sub-module ysyx_22050612_idu_dec: purely combinational inst -> packet, reused by the trace/difftest model.
- The stage wraps idu_dec and adds the M/S registers.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 → next cycle out_valid=1, OP_ADDI, rd=1, rs1=0, imm=5.
- beq x0,x0,-4 (0xFE000EE3) → fmt B, rd=0, imm=0xFFFFFFFFFFFFFFFC (XLEN=64).
- Hold out_ready=0 and present 3 back-to-back instructions:
  - first two accepted (M, S), third sees in_ready=0;
  - release → packets emerge in order, one per cycle, with no loss or duplication.
- Assert flush with M and S full → next cycle out_valid=0, in_ready=1; no flushed packet appears.
- Issue 0x00100073 → out_ebreak=1, OP_EBREAK.
- Issue 0x02208033: with the macro undefined, out_illegal=1; with it defined, OP_MUL with rs1=1, rs2=2.
- Assert rst mid-stream → next cycle out_valid=0 and in_ready=1.

Source files
------------

// File: rtl/idu_pkg.sv
// Shared types for the ysyx_22050612 instruction-decode stage: operation and
// format enums, RV64 opcode constants and the decoded-packet layout.
package idu_pkg;

    localparam int OP_W  = 7;
    localparam int IMM_W = 64;

    typedef enum logic [OP_W-1:0] {
        OP_ILLEGAL,
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LD, OP_LBU, OP_LHU, OP_LWU,
        OP_SB, OP_SH, OP_SW, OP_SD,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_ADDIW, OP_SLLIW, OP_SRLIW, OP_SRAIW,
        OP_ADDW, OP_SUBW, OP_SLLW, OP_SRLW, OP_SRAW,
        OP_ECALL, OP_EBREAK,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU,
        OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
    } op_e;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
    } fmt_e;

    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef struct packed {
        op_e              op;
        fmt_e             fmt;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [IMM_W-1:0] imm;
        logic [5:0]       shamt;
        logic             word;
        logic             illegal;
        logic             ebreak;
    } idu_pkt_t;

endpackage

// File: rtl/ysyx_22050612_idu_dec.sv
// Combinational RV64I decoder: raw instruction -> decoded packet.
// Define YSYX_22050612_IDU_MEXT_EN to also decode the RV64M set.
module ysyx_22050612_idu_dec
    import idu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0] inst,
    output idu_pkt_t    pkt
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        rv64;
    logic        shamt_ok;
    op_e         op;
    fmt_e        fmt;
    logic        word;
    logic [5:0]  shamt;
    logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc      = inst[6:0];
    assign f3       = inst[14:12];
    assign f7       = inst[31:25];
    assign rv64     = (XLEN == 64);
    assign shamt_ok = rv64 || !inst[25];

    assign imm_i = {{52{inst[31]}}, inst[31:20]};
    assign imm_s = {{52{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
    assign imm_j = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        op    = OP_ILLEGAL;
        fmt   = FMT_R;
        word  = 1'b0;
        shamt = 6'd0;
        case (opc)
            OPC_LUI:   begin op = OP_LUI;   fmt = FMT_U; end
            OPC_AUIPC: begin op = OP_AUIPC; fmt = FMT_U; end
            OPC_JAL:   begin op = OP_JAL;   fmt = FMT_J; end
            OPC_JALR: begin
                fmt = FMT_I;
                if (f3 == 3'b000) op = OP_JALR;
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                case (f3)
                    3'b000:  op = OP_BEQ;
                    3'b001:  op = OP_BNE;
                    3'b100:  op = OP_BLT;
                    3'b101:  op = OP_BGE;
                    3'b110:  op = OP_BLTU;
                    3'b111:  op = OP_BGEU;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                case (f3)
                    3'b000:  op = OP_LB;
                    3'b001:  op = OP_LH;
                    3'b010:  op = OP_LW;
                    3'b011:  op = rv64 ? OP_LD : OP_ILLEGAL;
                    3'b100:  op = OP_LBU;
                    3'b101:  op = OP_LHU;
                    3'b110:  op = rv64 ? OP_LWU : OP_ILLEGAL;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (f3)
                    3'b000:  op = OP_SB;
                    3'b001:  op = OP_SH;
                    3'b010:  op = OP_SW;
                    3'b011:  op = rv64 ? OP_SD : OP_ILLEGAL;
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_OP_IMM: begin
                fmt = FMT_I;
                case (f3)
                    3'b000: op = OP_ADDI;
                    3'b010: op = OP_SLTI;
                    3'b011: op = OP_SLTIU;
                    3'b100: op = OP_XORI;
                    3'b110: op = OP_ORI;
                    3'b111: op = OP_ANDI;
                    3'b001: begin
                        shamt = inst[25:20];
                        if (inst[31:26] == 6'b000000 && shamt_ok) op = OP_SLLI;
                    end
                    default: begin
                        shamt = inst[25:20];
                        if (shamt_ok && inst[31:26] == 6'b000000) op = OP_SRLI;
                        else if (shamt_ok && inst[31:26] == 6'b010000) op = OP_SRAI;
                    end
                endcase
            end
            OPC_OP_IMM_32: begin
                fmt  = FMT_I;
                word = 1'b1;
                if (rv64) begin
                    shamt = {1'b0, inst[24:20]};
                    case (f3)
                        3'b000:  op = OP_ADDIW;
                        3'b001:  op = (f7 == 7'b0000000) ? OP_SLLIW : OP_ILLEGAL;
                        3'b101: begin
                            if (f7 == 7'b0000000)      op = OP_SRLIW;
                            else if (f7 == 7'b0100000) op = OP_SRAIW;
                        end
                        default: op = OP_ILLEGAL;
                    endcase
                end
            end
            OPC_OP: begin
                fmt = FMT_R;
                case (f7)
                    7'b0000000: begin
                        case (f3)
                            3'b000:  op = OP_ADD;
                            3'b001:  op = OP_SLL;
                            3'b010:  op = OP_SLT;
                            3'b011:  op = OP_SLTU;
                            3'b100:  op = OP_XOR;
                            3'b101:  op = OP_SRL;
                            3'b110:  op = OP_OR;
                            default: op = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (f3 == 3'b000)      op = OP_SUB;
                        else if (f3 == 3'b101) op = OP_SRA;
                    end
                    7'b0000001: begin
`ifdef YSYX_22050612_IDU_MEXT_EN
                        case (f3)
                            3'b000:  op = OP_MUL;
                            3'b001:  op = OP_MULH;
                            3'b010:  op = OP_MULHSU;
                            3'b011:  op = OP_MULHU;
                            3'b100:  op = OP_DIV;
                            3'b101:  op = OP_DIVU;
                            3'b110:  op = OP_REM;
                            default: op = OP_REMU;
                        endcase
`else
                        op = OP_ILLEGAL;
`endif
                    end
                    default: op = OP_ILLEGAL;
                endcase
            end
            OPC_OP_32: begin
                fmt  = FMT_R;
                word = 1'b1;
                if (rv64) begin
                    case (f7)
                        7'b0000000: begin
                            if (f3 == 3'b000)      op = OP_ADDW;
                            else if (f3 == 3'b001) op = OP_SLLW;
                            else if (f3 == 3'b101) op = OP_SRLW;
                        end
                        7'b0100000: begin
                            if (f3 == 3'b000)      op = OP_SUBW;
                            else if (f3 == 3'b101) op = OP_SRAW;
                        end
                        7'b0000001: begin
`ifdef YSYX_22050612_IDU_MEXT_EN
                            case (f3)
                                3'b000:  op = OP_MULW;
                                3'b100:  op = OP_DIVW;
                                3'b101:  op = OP_DIVUW;
                                3'b110:  op = OP_REMW;
                                3'b111:  op = OP_REMUW;
                                default: op = OP_ILLEGAL;
                            endcase
`else
                            op = OP_ILLEGAL;
`endif
                        end
                        default: op = OP_ILLEGAL;
                    endcase
                end
            end
            OPC_SYSTEM: begin
                fmt = FMT_I;
                if (inst == INST_ECALL)       op = OP_ECALL;
                else if (inst == INST_EBREAK) op = OP_EBREAK;
            end
            default: op = OP_ILLEGAL;
        endcase
    end

    // Illegal encodings carry only the op/illegal flags; every other field reads zero.
    always_comb begin
        pkt         = '0;
        pkt.op      = op;
        pkt.illegal = (op == OP_ILLEGAL);
        pkt.ebreak  = (op == OP_EBREAK);
        if (op != OP_ILLEGAL) begin
            pkt.fmt   = fmt;
            pkt.word  = word;
            pkt.shamt = shamt;
            case (fmt)
                FMT_R: begin
                    pkt.rd  = inst[11:7];
                    pkt.rs1 = inst[19:15];
                    pkt.rs2 = inst[24:20];
                end
                FMT_I: begin
                    pkt.rd  = inst[11:7];
                    pkt.rs1 = inst[19:15];
                    pkt.imm = imm_i;
                end
                FMT_S: begin
                    pkt.rs1 = inst[19:15];
                    pkt.rs2 = inst[24:20];
                    pkt.imm = imm_s;
                end
                FMT_B: begin
                    pkt.rs1 = inst[19:15];
                    pkt.rs2 = inst[24:20];
                    pkt.imm = imm_b;
                end
                FMT_U: begin
                    pkt.rd  = inst[11:7];
                    pkt.imm = imm_u;
                end
                default: begin
                    pkt.rd  = inst[11:7];
                    pkt.imm = imm_j;
                end
            endcase
        end
    end

endmodule

// File: rtl/ysyx_22050612_idu_stage.sv
// Decode stage: wraps the combinational decoder with a registered output (M)
// and a one-entry skid buffer (S) so in_ready never depends on out_ready.
module ysyx_22050612_idu_stage
    import idu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int PC_W = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output op_e             out_op,
    output fmt_e            out_fmt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [5:0]      out_shamt,
    output logic            out_word,
    output logic            out_illegal,
    output logic            out_ebreak
);

    idu_pkt_t        dec_pkt;
    idu_pkt_t        m_pkt;
    idu_pkt_t        s_pkt;
    logic [PC_W-1:0] m_pc;
    logic [PC_W-1:0] s_pc;
    logic            m_valid;
    logic            s_valid;
    logic            accept;
    logic            m_free;

    ysyx_22050612_idu_dec #(
        .XLEN (XLEN)
    ) u_dec (
        .inst (in_inst),
        .pkt  (dec_pkt)
    );

    assign in_ready = !s_valid;
    assign accept   = in_valid && in_ready && !flush;
    assign m_free   = !m_valid || out_ready;

    // S only fills while M is stalled, so it is always older than any new input.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_pkt   <= '0;
            s_pkt   <= '0;
            m_pc    <= '0;
            s_pc    <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                m_pkt   <= s_pkt;
                m_pc    <= s_pc;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_pkt   <= dec_pkt;
                m_pc    <= in_pc;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s_pkt   <= dec_pkt;
            s_pc    <= in_pc;
            s_valid <= 1'b1;
        end
    end

    assign out_valid   = m_valid;
    assign out_pc      = m_pc;
    assign out_op      = m_pkt.op;
    assign out_fmt     = m_pkt.fmt;
    assign out_rd      = m_pkt.rd;
    assign out_rs1     = m_pkt.rs1;
    assign out_rs2     = m_pkt.rs2;
    assign out_imm     = m_pkt.imm[XLEN-1:0];
    assign out_shamt   = m_pkt.shamt;
    assign out_word    = m_pkt.word;
    assign out_illegal = m_pkt.illegal;
    assign out_ebreak  = m_pkt.ebreak;

endmodule

// File: tb/tb_ysyx_22050612_idu_stage.sv
// Directed-vector bench for the decode stage: decode fields, skid/backpressure
// ordering, flush and mid-stream reset.
module tb_ysyx_22050612_idu_stage;
    import idu_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    op_e         out_op;
    fmt_e        out_fmt;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [63:0] out_imm;
    logic [5:0]  out_shamt;
    logic        out_word;
    logic        out_illegal;
    logic        out_ebreak;

    int          n_vec;
    int          n_miss;
    logic [63:0] pc_ctr;

    ysyx_22050612_idu_stage #(
        .XLEN (64),
        .PC_W (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_op      (out_op),
        .out_fmt     (out_fmt),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_shamt   (out_shamt),
        .out_word    (out_word),
        .out_illegal (out_illegal),
        .out_ebreak  (out_ebreak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction through an unstalled stage, sampled right after the accepting edge.
    task automatic run_vec(input string tag, input logic [31:0] inst, input op_e op,
                           input fmt_e fmt, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [63:0] imm,
                           input logic [5:0] shamt, input logic word, input logic ill,
                           input logic ebk);
        logic [63:0] pc;
        pc       = pc_ctr;
        pc_ctr   = pc_ctr + 64'd4;
        in_inst  = inst;
        in_pc    = pc;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, ".valid"},   64'(out_valid),   64'd1);
        chk({tag, ".pc"},      out_pc,           pc);
        chk({tag, ".op"},      64'(out_op),      64'(op));
        chk({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
        chk({tag, ".ebreak"},  64'(out_ebreak),  64'(ebk));
        if (!ill) begin
            chk({tag, ".fmt"},   64'(out_fmt),   64'(fmt));
            chk({tag, ".rd"},    64'(out_rd),    64'(rd));
            chk({tag, ".rs1"},   64'(out_rs1),   64'(rs1));
            chk({tag, ".rs2"},   64'(out_rs2),   64'(rs2));
            chk({tag, ".imm"},   out_imm,        imm);
            chk({tag, ".shamt"}, 64'(out_shamt), 64'(shamt));
            chk({tag, ".word"},  64'(out_word),  64'(word));
        end
    endtask

    // Load M and S while execute is stalled.
    task automatic fill_two(input logic [63:0] pa, input logic [63:0] pb);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h0050_0093;
        in_pc     = pa;
        @(posedge clk);
        #1;
        in_inst   = 32'h1234_52B7;
        in_pc     = pb;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
    endtask

    initial begin
        logic [63:0] seen[$];
        logic [63:0] exp_pc[3];
        logic [63:0] obs;
        logic        will_accept;
        int          n_out;

        n_vec     = 0;
        n_miss    = 0;
        pc_ctr    = 64'h8000_0000;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 64'h0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.ready", 64'(in_ready),  64'd1);
        chk("rst.pc",    out_pc,         64'd0);
        chk("rst.imm",   out_imm,        64'd0);
        chk("rst.rd",    64'(out_rd),    64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_vec("addi",  32'h0050_0093, OP_ADDI,  FMT_I, 5'd1,  5'd0, 5'd0, 64'd5,                 6'd0,  1'b0, 1'b0, 1'b0);
        run_vec("beq",   32'hFE00_0EE3, OP_BEQ,   FMT_B, 5'd0,  5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 6'd0,  1'b0, 1'b0, 1'b0);
        run_vec("lui",   32'h1234_52B7, OP_LUI,   FMT_U, 5'd5,  5'd0, 5'd0, 64'h0000_0000_1234_5000, 6'd0,  1'b0, 1'b0, 1'b0);
        run_vec("sw",    32'hFE20_AC23, OP_SW,    FMT_S, 5'd0,  5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFF8, 6'd0,  1'b0, 1'b0, 1'b0);
        run_vec("jal",   32'h0080_00EF, OP_JAL,   FMT_J, 5'd1,  5'd0, 5'd0, 64'd8,                 6'd0,  1'b0, 1'b0, 1'b0);
        run_vec("ld",    32'h0101_3503, OP_LD,    FMT_I, 5'd10, 5'd2, 5'd0, 64'd16,                6'd0,  1'b0, 1'b0, 1'b0);
        run_vec("srai",  32'h4212_5193, OP_SRAI,  FMT_I, 5'd3,  5'd4, 5'd0, 64'h421,               6'd33, 1'b0, 1'b0, 1'b0);
        run_vec("srli",  32'h03F1_5113, OP_SRLI,  FMT_I, 5'd2,  5'd2, 5'd0, 64'h03F,               6'd63, 1'b0, 1'b0, 1'b0);
        run_vec("addw",  32'h0073_02BB, OP_ADDW,  FMT_R, 5'd5,  5'd6, 5'd7, 64'd0,                 6'd0,  1'b1, 1'b0, 1'b0);
        run_vec("ebrk",  32'h0010_0073, OP_EBREAK, FMT_I, 5'd0, 5'd0, 5'd0, 64'd1,                 6'd0,  1'b0, 1'b0, 1'b1);
        run_vec("ecall", 32'h0000_0073, OP_ECALL, FMT_I, 5'd0,  5'd0, 5'd0, 64'd0,                 6'd0,  1'b0, 1'b0, 1'b0);
`ifdef YSYX_22050612_IDU_MEXT_EN
        run_vec("mul",   32'h0220_8033, OP_MUL,   FMT_R, 5'd0,  5'd1, 5'd2, 64'd0,                 6'd0,  1'b0, 1'b0, 1'b0);
`else
        run_vec("mul",   32'h0220_8033, OP_ILLEGAL, FMT_R, 5'd0, 5'd0, 5'd0, 64'd0,                6'd0,  1'b0, 1'b1, 1'b0);
`endif
        run_vec("ones",  32'hFFFF_FFFF, OP_ILLEGAL, FMT_R, 5'd0, 5'd0, 5'd0, 64'd0,                6'd0,  1'b0, 1'b1, 1'b0);
        run_vec("slliw", 32'h0200_909B, OP_ILLEGAL, FMT_R, 5'd0, 5'd0, 5'd0, 64'd0,                6'd0,  1'b0, 1'b1, 1'b0);

        // Backpressure: A -> M, B -> S, C must wait; then all three drain in order.
        @(posedge clk);
        #1;
        exp_pc[0] = 64'h1000;
        exp_pc[1] = 64'h1004;
        exp_pc[2] = 64'h1008;
        fill_two(exp_pc[0], exp_pc[1]);
        in_valid = 1'b1;
        in_inst  = 32'h0080_00EF;
        in_pc    = exp_pc[2];
        chk("bp.ready_full", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("bp.ready_hold", 64'(in_ready),  64'd0);
        chk("bp.valid_hold", 64'(out_valid), 64'd1);
        chk("bp.pc_hold",    out_pc,         exp_pc[0]);
        chk("bp.rd_hold",    64'(out_rd),    64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            will_accept = in_valid && in_ready;
            if (out_valid && out_ready) seen.push_back(out_pc);
            @(posedge clk);
            #1;
            if (will_accept) in_valid = 1'b0;
        end
        chk("bp.count", 64'(seen.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            obs = (i < seen.size()) ? seen[i] : '1;
            chk($sformatf("bp.order%0d", i), obs, exp_pc[i]);
        end

        // Flush with M and S full, then flush again with in_ready high.
        fill_two(64'h2000, 64'h2004);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = 32'h0080_00EF;
        in_pc    = 64'h2008;
        @(posedge clk);
        #1;
        chk("flush.valid", 64'(out_valid), 64'd0);
        chk("flush.ready", 64'(in_ready),  64'd1);
        in_pc = 64'h200C;
        @(posedge clk);
        #1;
        chk("flush.drop", 64'(out_valid), 64'd0);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_out     = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid) n_out++;
        end
        chk("flush.none_out", 64'(n_out), 64'd0);

        // Reset mid-stream.
        @(posedge clk);
        #1;
        fill_two(64'h3000, 64'h3004);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst.valid", 64'(out_valid), 64'd0);
        chk("mrst.ready", 64'(in_ready),  64'd1);
        chk("mrst.pc",    out_pc,         64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_vec("post", 32'h0050_0093, OP_ADDI, FMT_I, 5'd1, 5'd0, 5'd0, 64'd5, 6'd0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
